// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage constants: default widths, reset PC and the canonical NOP.
package instr_fetch_pkg;

   localparam int          DEF_XLEN     = 32;
   localparam int          DEF_DEPTH    = 2;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   // addi x0, x0, 0 -- what decode sees while no instruction is valid
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response plus the
// decode-side valid/stall handshake and the redirect input.
//
// Handshakes:
//   Imem: a request transfers on a cycle where Imem_req && Imem_ready. Its
//         single response is the first later cycle with Imem_rvalid high.
//   Decode: the head transfers on a cycle where Inst_valid && !Stall &&
//         !Redirect. While Stall is high, Instruction/PC_out hold steady.
interface instr_fetch_if
   import instr_fetch_pkg::*;
#(
   parameter int XLEN = DEF_XLEN
) ();

   logic            Imem_req;
   logic [XLEN-1:0] Imem_addr;
   logic            Imem_ready;
   logic            Imem_rvalid;
   logic [31:0]     Imem_rdata;
   logic            Redirect;
   logic [XLEN-1:0] Redirect_pc;
   logic            Stall;
   logic            Inst_valid;
   logic [31:0]     Instruction;
   logic [XLEN-1:0] PC_out;

   // fetch stage side
   modport master (
      output Imem_req, Imem_addr, Inst_valid, Instruction, PC_out,
      input  Imem_ready, Imem_rvalid, Imem_rdata, Redirect, Redirect_pc, Stall
   );

   // memory / decode / branch-resolution side
   modport slave (
      input  Imem_req, Imem_addr, Inst_valid, Instruction, PC_out,
      output Imem_ready, Imem_rvalid, Imem_rdata, Redirect, Redirect_pc, Stall
   );

endinterface

// File: rtl/instr_fetch_queue.sv
// fetch_queue: DEPTH-entry FIFO of {pc, instr} with flush. The head is read
// straight out of the storage registers so it has no path from any input.
module fetch_queue
   import instr_fetch_pkg::*;
#(
   parameter int XLEN  = DEF_XLEN,
   parameter int DEPTH = DEF_DEPTH,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_push,
   input  logic [XLEN-1:0] i_pc,
   input  logic [31:0]     i_instr,
   input  logic            i_pop,
   input  logic            i_flush,
   output logic [CW-1:0]   o_count,
   output logic [XLEN-1:0] o_head_pc,
   output logic [31:0]     o_head_instr
);

   logic [XLEN-1:0] r_pc_mem    [DEPTH];
   logic [31:0]     r_instr_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;

   // entry storage; stale contents are harmless because count gates validity
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_pc_mem[r_wr_ptr]    <= i_pc;
         r_instr_mem[r_wr_ptr] <= i_instr;
      end
   end

   // pointers wrap naturally since DEPTH is a power of two; flush empties at once
   always_ff @(posedge clk) begin
      if (reset || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      end
   end

   // occupancy; a simultaneous push and pop leaves it unchanged
   always_ff @(posedge clk) begin
      if (reset || i_flush) begin
         r_count <= '0;
      end else if (i_push && !i_pop) begin
         r_count <= r_count + CW'(1);
      end else if (!i_push && i_pop) begin
         r_count <= r_count - CW'(1);
      end
   end

   assign o_count      = r_count;
   assign o_head_pc    = r_pc_mem[r_rd_ptr];
   assign o_head_instr = r_instr_mem[r_rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: owns the fetch PC, keeps at most one Imem request in flight,
// drops the response of a request made obsolete by a redirect, and hands
// buffered {pc, instr} pairs to decode.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int              XLEN     = DEF_XLEN,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC),
   parameter int              DEPTH    = DEF_DEPTH
) (
   input logic           clk,
   input logic           reset,
   instr_fetch_if.master bus
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [XLEN-1:0] r_fpc;
   logic [XLEN-1:0] r_req_pc;
   logic [XLEN-1:0] r_last_pc;
   logic            r_outstanding;
   logic            r_discard;

   logic [CW-1:0]   w_count;
   logic [XLEN-1:0] w_head_pc;
   logic [31:0]     w_head_instr;
   logic            w_valid;
   logic            w_pop;
   logic            w_resp;
   logic            w_push;
   logic [CW:0]     w_occ;
   logic            w_space;
   logic            w_req;
   logic            w_accept;
   logic [XLEN-1:0] w_redirect_pc;

   assign w_valid = (w_count != '0);
   // redirect outranks a pop: the head is being thrown away anyway
   assign w_pop   = w_valid & ~bus.Stall & ~bus.Redirect;
   // rvalid only means something while a request is in flight
   assign w_resp  = bus.Imem_rvalid & r_outstanding;
   assign w_push  = w_resp & ~r_discard & ~bus.Redirect;

   // queued entries plus the in-flight slot, after this cycle's pop, must
   // leave room for one more word so a response can never overflow the queue
   assign w_occ   = {1'b0, w_count} + (CW+1)'(r_outstanding) - (CW+1)'(w_pop);
   assign w_space = (w_occ < (CW+1)'(DEPTH));

   assign w_req    = ~reset & ~bus.Redirect & (~r_outstanding | bus.Imem_rvalid) & w_space;
   assign w_accept = w_req & bus.Imem_ready;

   assign w_redirect_pc = bus.Redirect_pc & ~XLEN'(3);

   fetch_queue #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk          (clk),
      .reset        (reset),
      .i_push       (w_push),
      .i_pc         (r_req_pc),
      .i_instr      (bus.Imem_rdata),
      .i_pop        (w_pop),
      .i_flush      (bus.Redirect),
      .o_count      (w_count),
      .o_head_pc    (w_head_pc),
      .o_head_instr (w_head_instr)
   );

   // fetch PC: restart on redirect, otherwise advance past each accepted request
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fpc <= RESET_PC;
      end else if (bus.Redirect) begin
         r_fpc <= w_redirect_pc;
      end else if (w_accept) begin
         r_fpc <= r_fpc + XLEN'(4);
      end
   end

   // PC of the request in flight, paired with its data when it returns
   always_ff @(posedge clk) begin
      if (reset) begin
         r_req_pc <= '0;
      end else if (w_accept) begin
         r_req_pc <= r_fpc;
      end
   end

   // in-flight flag; a new accept in the response cycle keeps it set
   always_ff @(posedge clk) begin
      if (reset) begin
         r_outstanding <= 1'b0;
      end else if (w_accept) begin
         r_outstanding <= 1'b1;
      end else if (w_resp) begin
         r_outstanding <= 1'b0;
      end
   end

   // discard marks an in-flight request whose word belongs to the old path
   always_ff @(posedge clk) begin
      if (reset) begin
         r_discard <= 1'b0;
      end else if (bus.Redirect) begin
         r_discard <= r_outstanding & ~bus.Imem_rvalid;
      end else if (w_resp && r_discard) begin
         r_discard <= 1'b0;
      end
   end

   // remember the last presented PC so PC_out holds it while the queue is empty
   always_ff @(posedge clk) begin
      if (reset) begin
         r_last_pc <= '0;
      end else if (w_valid) begin
         r_last_pc <= w_head_pc;
      end
   end

   assign bus.Imem_req    = w_req;
   assign bus.Imem_addr   = r_fpc;
   assign bus.Inst_valid  = w_valid;
   assign bus.Instruction = w_valid ? w_head_instr : NOP_INSTR;
   assign bus.PC_out      = w_valid ? w_head_pc : r_last_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a small instruction-memory responder
// that returns the request address as data after a programmable latency.
module tb_instr_fetch;
   import instr_fetch_pkg::*;

   localparam int          XLEN   = 32;
   localparam int          DEPTH  = 2;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   int   mem_lat = 1;

   instr_fetch_if #(.XLEN(XLEN)) bus ();

   instr_fetch #(.XLEN(XLEN), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // clock
   always #5 clk = ~clk;

   // memory responder: samples an accept at the negedge, answers mem_lat cycles later
   initial begin
      logic            acc;
      logic            rv_now;
      logic            rst_now;
      logic            pend;
      logic [XLEN-1:0] acc_addr;
      logic [XLEN-1:0] pend_addr;
      int              cnt;
      bus.Imem_ready  = 1'b1;
      bus.Imem_rvalid = 1'b0;
      bus.Imem_rdata  = '0;
      pend = 1'b0;
      pend_addr = '0;
      cnt = 0;
      forever begin
         @(negedge clk);
         acc      = bus.Imem_req & bus.Imem_ready;
         acc_addr = bus.Imem_addr;
         rv_now   = bus.Imem_rvalid;
         rst_now  = reset;
         @(posedge clk);
         #1;
         if (rst_now) begin
            pend = 1'b0;
            bus.Imem_rvalid = 1'b0;
         end else begin
            if (rv_now) bus.Imem_rvalid = 1'b0;
            if (acc) begin
               pend = 1'b1;
               pend_addr = acc_addr;
               cnt = mem_lat - 1;
            end else if (pend && cnt > 0) begin
               cnt--;
            end
            if (pend && cnt == 0) begin
               bus.Imem_rvalid = 1'b1;
               bus.Imem_rdata  = pend_addr;
               pend = 1'b0;
            end
         end
      end
   end

   // the queue must never take a push while full without a matching pop
   always @(negedge clk) begin
      if (!reset && dut.w_push && !dut.w_pop) begin
         n_cmp++;
         if (int'(dut.w_count) >= DEPTH) begin
            n_err++;
            $display("FAIL overflow: count=%0d with push, limit %0d", dut.w_count, DEPTH);
         end
      end
   end

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.Stall = 1'b0;
      bus.Redirect = 1'b0;
      bus.Redirect_pc = '0;
      mem_lat = 1;
      repeat (2) step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.Stall = 1'b0;
      bus.Redirect = 1'b0;
      bus.Redirect_pc = '0;
      repeat (2) step();
      @(negedge clk);
      n_cmp++; if (bus.Inst_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", bus.Inst_valid); end
      n_cmp++; if (bus.Imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b exp 0", bus.Imem_req); end
      n_cmp++; if (bus.Imem_addr !== RST_PC) begin n_err++; $display("FAIL rst_addr got %h exp %h", bus.Imem_addr, RST_PC); end
      n_cmp++; if (bus.Instruction !== 32'h0000_0013) begin n_err++; $display("FAIL rst_instr got %h exp 00000013", bus.Instruction); end
      n_cmp++; if (bus.PC_out !== 32'h0) begin n_err++; $display("FAIL rst_pc got %h exp 0", bus.PC_out); end
   endtask

   task automatic test_stream();
      do_reset();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         n_cmp++; if (bus.Imem_req !== 1'b1) begin n_err++; $display("FAIL stream_req k=%0d got %b exp 1", k, bus.Imem_req); end
         n_cmp++; if (bus.Imem_addr !== 32'(4*k)) begin n_err++; $display("FAIL stream_addr k=%0d got %h exp %h", k, bus.Imem_addr, 32'(4*k)); end
         n_cmp++; if (bus.Inst_valid !== (k >= 2)) begin n_err++; $display("FAIL stream_valid k=%0d got %b exp %b", k, bus.Inst_valid, (k >= 2)); end
         if (k >= 2) begin
            n_cmp++; if (bus.PC_out !== 32'(4*(k-2))) begin n_err++; $display("FAIL stream_pc k=%0d got %h exp %h", k, bus.PC_out, 32'(4*(k-2))); end
            n_cmp++; if (bus.Instruction !== 32'(4*(k-2))) begin n_err++; $display("FAIL stream_instr k=%0d got %h exp %h", k, bus.Instruction, 32'(4*(k-2))); end
         end
         step();
      end
   endtask

   task automatic test_stall();
      do_reset();
      for (int k = 0; k <= 12; k++) begin
         bus.Stall = (k >= 4 && k <= 8);
         @(negedge clk);
         if (k >= 4 && k <= 8) begin
            n_cmp++; if (bus.Inst_valid !== 1'b1 || bus.PC_out !== 32'h8) begin n_err++; $display("FAIL stall_head k=%0d got v=%b pc=%h exp v=1 pc=00000008", k, bus.Inst_valid, bus.PC_out); end
            n_cmp++; if (bus.Instruction !== 32'h8) begin n_err++; $display("FAIL stall_instr k=%0d got %h exp 00000008", k, bus.Instruction); end
            n_cmp++; if (bus.Imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req k=%0d got %b exp 0", k, bus.Imem_req); end
         end
         if (k >= 5 && k <= 8) begin
            n_cmp++; if (int'(dut.w_count) != 2) begin n_err++; $display("FAIL stall_full k=%0d got %0d exp 2", k, dut.w_count); end
         end
         if (k == 9) begin
            n_cmp++; if (bus.Imem_req !== 1'b1 || bus.Imem_addr !== 32'h10) begin n_err++; $display("FAIL stall_resume_req got req=%b addr=%h exp req=1 addr=00000010", bus.Imem_req, bus.Imem_addr); end
         end
         if (k >= 9) begin
            n_cmp++; if (bus.Inst_valid !== 1'b1 || bus.PC_out !== 32'(4*(k-7))) begin n_err++; $display("FAIL stall_resume_pc k=%0d got v=%b pc=%h exp v=1 pc=%h", k, bus.Inst_valid, bus.PC_out, 32'(4*(k-7))); end
            n_cmp++; if (bus.Instruction !== 32'(4*(k-7))) begin n_err++; $display("FAIL stall_resume_instr k=%0d got %h exp %h", k, bus.Instruction, 32'(4*(k-7))); end
         end
         step();
      end
      bus.Stall = 1'b0;
   endtask

   task automatic test_redirect_outstanding();
      do_reset();
      mem_lat = 3;
      for (int k = 0; k <= 10; k++) begin
         bus.Stall = (k == 4 || k == 5);
         bus.Redirect = (k == 5);
         bus.Redirect_pc = 32'h100;
         @(negedge clk);
         if (k == 4) begin
            n_cmp++; if (bus.Inst_valid !== 1'b1 || bus.PC_out !== 32'h0) begin n_err++; $display("FAIL rdo_head got v=%b pc=%h exp v=1 pc=0", bus.Inst_valid, bus.PC_out); end
         end
         if (k == 5) begin
            n_cmp++; if (bus.Imem_req !== 1'b0) begin n_err++; $display("FAIL rdo_req_redirect got %b exp 0", bus.Imem_req); end
         end
         if (k == 6) begin
            n_cmp++; if (bus.Inst_valid !== 1'b0 || bus.Instruction !== 32'h13) begin n_err++; $display("FAIL rdo_flush got v=%b instr=%h exp v=0 instr=00000013", bus.Inst_valid, bus.Instruction); end
            n_cmp++; if (bus.PC_out !== 32'h0) begin n_err++; $display("FAIL rdo_pc_hold got %h exp 0", bus.PC_out); end
            n_cmp++; if (bus.Imem_req !== 1'b1 || bus.Imem_addr !== 32'h100) begin n_err++; $display("FAIL rdo_refetch got req=%b addr=%h exp req=1 addr=00000100", bus.Imem_req, bus.Imem_addr); end
         end
         if (k >= 7 && k <= 9) begin
            n_cmp++; if (bus.Inst_valid !== 1'b0) begin n_err++; $display("FAIL rdo_stale k=%0d got v=%b pc=%h exp v=0", k, bus.Inst_valid, bus.PC_out); end
         end
         if (k == 10) begin
            n_cmp++; if (bus.Inst_valid !== 1'b1 || bus.PC_out !== 32'h100 || bus.Instruction !== 32'h100) begin n_err++; $display("FAIL rdo_first got v=%b pc=%h instr=%h exp v=1 pc=00000100 instr=00000100", bus.Inst_valid, bus.PC_out, bus.Instruction); end
         end
         step();
      end
      bus.Stall = 1'b0;
      bus.Redirect = 1'b0;
   endtask

   task automatic test_redirect_coincident();
      do_reset();
      for (int k = 0; k <= 6; k++) begin
         bus.Redirect = (k == 3);
         bus.Redirect_pc = 32'h203;
         @(negedge clk);
         if (k == 3) begin
            n_cmp++; if (bus.Imem_req !== 1'b0) begin n_err++; $display("FAIL rdc_req got %b exp 0", bus.Imem_req); end
         end
         if (k == 4) begin
            n_cmp++; if (bus.Imem_req !== 1'b1 || bus.Imem_addr !== 32'h200) begin n_err++; $display("FAIL rdc_addr got req=%b addr=%h exp req=1 addr=00000200", bus.Imem_req, bus.Imem_addr); end
            n_cmp++; if (bus.Inst_valid !== 1'b0 || bus.Instruction !== 32'h13) begin n_err++; $display("FAIL rdc_flush got v=%b instr=%h exp v=0 instr=00000013", bus.Inst_valid, bus.Instruction); end
            n_cmp++; if (bus.PC_out !== 32'h4) begin n_err++; $display("FAIL rdc_pc_hold got %h exp 00000004", bus.PC_out); end
         end
         if (k == 5) begin
            n_cmp++; if (bus.Inst_valid !== 1'b0 || bus.Imem_addr !== 32'h204) begin n_err++; $display("FAIL rdc_dropped got v=%b addr=%h exp v=0 addr=00000204", bus.Inst_valid, bus.Imem_addr); end
         end
         if (k == 6) begin
            n_cmp++; if (bus.Inst_valid !== 1'b1 || bus.PC_out !== 32'h200 || bus.Instruction !== 32'h200) begin n_err++; $display("FAIL rdc_first got v=%b pc=%h instr=%h exp v=1 pc=00000200 instr=00000200", bus.Inst_valid, bus.PC_out, bus.Instruction); end
         end
         step();
      end
      bus.Redirect = 1'b0;
   endtask

   task automatic test_wrap();
      logic [31:0] exp_addr [4];
      exp_addr[1] = 32'hFFFF_FFF8;
      exp_addr[2] = 32'hFFFF_FFFC;
      exp_addr[3] = 32'h0000_0000;
      do_reset();
      for (int k = 0; k <= 5; k++) begin
         bus.Redirect = (k == 0);
         bus.Redirect_pc = 32'hFFFF_FFF8;
         @(negedge clk);
         if (k >= 1 && k <= 3) begin
            n_cmp++; if (bus.Imem_req !== 1'b1 || bus.Imem_addr !== exp_addr[k]) begin n_err++; $display("FAIL wrap_addr k=%0d got req=%b addr=%h exp req=1 addr=%h", k, bus.Imem_req, bus.Imem_addr, exp_addr[k]); end
         end
         if (k >= 3) begin
            n_cmp++; if (bus.Inst_valid !== 1'b1 || bus.PC_out !== exp_addr[k-2] || bus.Instruction !== exp_addr[k-2]) begin n_err++; $display("FAIL wrap_pc k=%0d got v=%b pc=%h instr=%h exp %h", k, bus.Inst_valid, bus.PC_out, bus.Instruction, exp_addr[k-2]); end
         end
         step();
      end
      bus.Redirect = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int k = 0; k <= 9; k++) begin
         bus.Stall = (k >= 4 && k <= 6);
         reset = (k == 6);
         @(negedge clk);
         if (k == 5) begin
            n_cmp++; if (int'(dut.w_count) != 2 || bus.PC_out !== 32'h8) begin n_err++; $display("FAIL rmid_full got count=%0d pc=%h exp count=2 pc=00000008", dut.w_count, bus.PC_out); end
         end
         if (k == 6) begin
            n_cmp++; if (bus.Imem_req !== 1'b0) begin n_err++; $display("FAIL rmid_req got %b exp 0", bus.Imem_req); end
         end
         if (k == 7) begin
            n_cmp++; if (bus.Inst_valid !== 1'b0 || bus.Instruction !== 32'h13) begin n_err++; $display("FAIL rmid_out got v=%b instr=%h exp v=0 instr=00000013", bus.Inst_valid, bus.Instruction); end
            n_cmp++; if (bus.Imem_addr !== RST_PC || bus.PC_out !== 32'h0) begin n_err++; $display("FAIL rmid_addr got addr=%h pc=%h exp addr=%h pc=0", bus.Imem_addr, bus.PC_out, RST_PC); end
            n_cmp++; if (bus.Imem_req !== 1'b1) begin n_err++; $display("FAIL rmid_restart_req got %b exp 1", bus.Imem_req); end
         end
         if (k == 8) begin
            n_cmp++; if (bus.Inst_valid !== 1'b0) begin n_err++; $display("FAIL rmid_gap got %b exp 0", bus.Inst_valid); end
         end
         if (k == 9) begin
            n_cmp++; if (bus.Inst_valid !== 1'b1 || bus.PC_out !== 32'h0 || bus.Instruction !== 32'h0) begin n_err++; $display("FAIL rmid_first got v=%b pc=%h instr=%h exp v=1 pc=0 instr=0", bus.Inst_valid, bus.PC_out, bus.Instruction); end
         end
         step();
      end
      bus.Stall = 1'b0;
      reset = 1'b0;
   endtask

   // test sequence and report
   initial begin
      bus.Stall = 1'b0;
      bus.Redirect = 1'b0;
      bus.Redirect_pc = '0;
      test_reset();
      test_stream();
      test_stall();
      test_redirect_outstanding();
      test_redirect_coincident();
      test_wrap();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
